// File: rtl/lpc_reg_bank_if.sv
// LPC-side register bus between the slave decoder and the register bank.
// The master drives address, strobes and write data; the bank returns registered read data.
interface lpc_reg_bank_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] Addr;
  logic              Wr;
  logic              Rd;
  logic [7:0]        DataWrSW;
  logic [7:0]        DataRd;
  logic              RdValid;

  modport master (output Addr, Wr, Rd, DataWrSW, input DataRd, RdValid);
  modport slave  (input Addr, Wr, Rd, DataWrSW, output DataRd, RdValid);
endinterface

// File: rtl/lpc_reg_bank.sv
// Parametrised LPC register bank with per-bit attributes (hardware-owned, write-1-to-clear, read/write, constant),
// a registered read port, per-register write strobes and a maskable interrupt.
module lpc_reg_bank #(
  parameter int                     NUM_REGS     = 32,
  parameter int                     ADDR_W       = 8,
  parameter logic [NUM_REGS*8-1:0]  RESET_VAL    = '0,
  parameter logic [NUM_REGS*8-1:0]  HW_MASK      = '0,
  parameter logic [NUM_REGS*8-1:0]  W1C_MASK     = '0,
  parameter logic [NUM_REGS*8-1:0]  RW_MASK      = '0,
  parameter int                     IRQ_STAT_IDX = 2,
  parameter int                     IRQ_EN_IDX   = 3
) (
  input  logic                  PciReset,
  input  logic                  LpcClock,
  lpc_reg_bank_if.slave         lpcBus,
  input  logic [NUM_REGS*8-1:0] HwVal,
  input  logic [NUM_REGS*8-1:0] HwEvent,
  output logic [NUM_REGS-1:0]   WrPulse,
  output logic [NUM_REGS*8-1:0] RegFlat,
  output logic                  Irq
);

  localparam logic [7:0] IrqStatMask = W1C_MASK[8*IRQ_STAT_IDX +: 8];

  logic [NUM_REGS*8-1:0] regQ;
  logic [NUM_REGS*8-1:0] regD;
  logic [NUM_REGS-1:0]   wrSel;
  logic [7:0]            rdMux;
  logic [7:0]            dataRdQ;
  logic                  rdValidQ;
  logic                  irqQ;
  logic                  irqNext;

  // Full-width address compare, so out-of-range writes select nothing
  // and out-of-range reads fall through to the all-ones default.
  always_comb begin
    wrSel = '0;
    rdMux = 8'hFF;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (lpcBus.Addr == ADDR_W'(i)) begin
        wrSel[i] = lpcBus.Wr;
        rdMux    = regQ[8*i +: 8];
      end
    end
  end

  // Bit class priority: HW, then W1C (set beats clear), then RW, else constant.
  always_comb begin
    regD = regQ;
    for (int i = 0; i < NUM_REGS; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (HW_MASK[8*i+b]) begin
          regD[8*i+b] = HwVal[8*i+b];
        end else if (W1C_MASK[8*i+b]) begin
          regD[8*i+b] = (regQ[8*i+b] & ~(wrSel[i] & lpcBus.DataWrSW[b])) | HwEvent[8*i+b];
        end else if (RW_MASK[8*i+b]) begin
          regD[8*i+b] = wrSel[i] ? lpcBus.DataWrSW[b] : regQ[8*i+b];
        end else begin
          regD[8*i+b] = RESET_VAL[8*i+b];
        end
      end
    end
  end

  assign irqNext = |(regQ[8*IRQ_STAT_IDX +: 8] & IrqStatMask & regQ[8*IRQ_EN_IDX +: 8]);

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      regQ     <= RESET_VAL;
      dataRdQ  <= 8'h00;
      rdValidQ <= 1'b0;
      WrPulse  <= '0;
      irqQ     <= 1'b0;
    end else begin
      regQ     <= regD;
      rdValidQ <= lpcBus.Rd;
      WrPulse  <= wrSel;
      irqQ     <= irqNext;
      if (lpcBus.Rd) begin
        dataRdQ <= rdMux;
      end
    end
  end

  assign lpcBus.DataRd  = dataRdQ;
  assign lpcBus.RdValid = rdValidQ;
  assign RegFlat        = regQ;
  assign Irq            = irqQ;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// Self-checking bench for lpc_reg_bank: a 32-register instance with mixed attribute masks
// and an 8-register instance for the write-strobe sweep; reads are checked through a scoreboard queue.
module tb_lpc_reg_bank;

  localparam logic [255:0] RV   = 256'h5A;
  localparam logic [255:0] HWM  = 256'h04 << 32;
  localparam logic [255:0] W1CM = 256'hFF << 16;
  localparam logic [255:0] RWM  = (256'h1B << 32) | (256'hFF << 24) | (256'hFF << 8);
  localparam logic [63:0]  RWM8 = {64{1'b1}};

  logic         LpcClock = 1'b0;
  logic         PciReset;
  logic [255:0] hwVal, hwEvent, regFlat;
  logic [31:0]  wrPulse;
  logic         irq;
  logic [63:0]  hwVal8, hwEvent8, regFlat8;
  logic [7:0]   wrPulse8;
  logic         irq8;

  int total = 0;
  int bad   = 0;
  logic [7:0] sbQ[$];

  lpc_reg_bank_if #(.ADDR_W(8)) bus ();
  lpc_reg_bank_if #(.ADDR_W(3)) bus8 ();

  lpc_reg_bank #(
    .NUM_REGS(32), .ADDR_W(8), .RESET_VAL(RV), .HW_MASK(HWM), .W1C_MASK(W1CM),
    .RW_MASK(RWM), .IRQ_STAT_IDX(2), .IRQ_EN_IDX(3)
  ) dut (
    .PciReset(PciReset), .LpcClock(LpcClock), .lpcBus(bus), .HwVal(hwVal),
    .HwEvent(hwEvent), .WrPulse(wrPulse), .RegFlat(regFlat), .Irq(irq)
  );

  lpc_reg_bank #(
    .NUM_REGS(8), .ADDR_W(3), .RESET_VAL(64'h0), .HW_MASK(64'h0), .W1C_MASK(64'h0),
    .RW_MASK(RWM8), .IRQ_STAT_IDX(2), .IRQ_EN_IDX(3)
  ) dut8 (
    .PciReset(PciReset), .LpcClock(LpcClock), .lpcBus(bus8), .HwVal(hwVal8),
    .HwEvent(hwEvent8), .WrPulse(wrPulse8), .RegFlat(regFlat8), .Irq(irq8)
  );

  always #5 LpcClock = ~LpcClock;

  initial begin
    #100000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  task automatic monitorRd();
    logic [7:0] e;
    forever begin
      @(negedge LpcClock);
      if (bus.RdValid === 1'b1) begin
        total++;
        if (sbQ.size() == 0) begin
          bad++;
          $display("FAIL read_unexpected got=%h (no read outstanding)", bus.DataRd);
        end else begin
          e = sbQ.pop_front();
          if (bus.DataRd !== e) begin
            bad++;
            $display("FAIL read_data got=%h exp=%h", bus.DataRd, e);
          end
        end
      end
    end
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    bus.Addr = a; bus.DataWrSW = d; bus.Wr = 1'b1;
    @(negedge LpcClock);
    bus.Wr = 1'b0;
  endtask

  task automatic readReg(input logic [7:0] a, input logic [7:0] e);
    sbQ.push_back(e);
    bus.Addr = a; bus.Rd = 1'b1;
    @(negedge LpcClock);
    bus.Rd = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge LpcClock);
    PciReset = 1'b1;
    writeReg(8'd3, 8'h01);
    hwEvent[16] = 1'b1;
    @(negedge LpcClock);
    hwEvent = '0;
    writeReg(8'd1, 8'hC3);
    // raw read+write so the scoreboard is not involved in the aborted access
    bus.Addr = 8'd1; bus.DataWrSW = 8'h77; bus.Wr = 1'b1; bus.Rd = 1'b1;
    @(posedge LpcClock);
    #2;
    total++; if (bus.RdValid !== 1'b1) begin bad++; $display("FAIL pre_reset_rdvalid got=%b exp=1", bus.RdValid); end
    total++; if (bus.DataRd !== 8'hC3) begin bad++; $display("FAIL pre_reset_datard got=%h exp=c3", bus.DataRd); end
    total++; if (wrPulse !== 32'h2) begin bad++; $display("FAIL pre_reset_wrpulse got=%h exp=00000002", wrPulse); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    PciReset = 1'b0;
    #1;
    total++; if (regFlat !== RV) begin bad++; $display("FAIL reset_regflat got=%h exp=%h", regFlat, RV); end
    total++; if (bus.DataRd !== 8'h00) begin bad++; $display("FAIL reset_datard got=%h exp=00", bus.DataRd); end
    total++; if (bus.RdValid !== 1'b0) begin bad++; $display("FAIL reset_rdvalid got=%b exp=0", bus.RdValid); end
    total++; if (wrPulse !== 32'h0) begin bad++; $display("FAIL reset_wrpulse got=%h exp=0", wrPulse); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus.Wr = 1'b0; bus.Rd = 1'b0;
    @(negedge LpcClock);
    PciReset = 1'b1;
    writeReg(8'd0, 8'hFF);
    total++; if (regFlat[7:0] !== 8'h5A) begin bad++; $display("FAIL const_reg0 got=%h exp=5a", regFlat[7:0]); end
    total++; if (wrPulse !== 32'h1) begin bad++; $display("FAIL const_wrpulse got=%h exp=00000001", wrPulse); end
    @(negedge LpcClock);
    total++; if (wrPulse !== 32'h0) begin bad++; $display("FAIL const_wrpulse_once got=%h exp=0", wrPulse); end
  endtask

  task automatic test_mixed_masks();
    hwVal[34] = 1'b1;
    writeReg(8'd4, 8'hFF);
    total++; if (regFlat[39:32] !== 8'h1F) begin bad++; $display("FAIL mixed_write got=%h exp=1f", regFlat[39:32]); end
    readReg(8'd4, 8'h1F);
    hwVal[34] = 1'b0;
    @(negedge LpcClock);
    total++; if (regFlat[39:32] !== 8'h1B) begin bad++; $display("FAIL mixed_hw_drop got=%h exp=1b", regFlat[39:32]); end
    writeReg(8'd4, 8'h00);
    total++; if (regFlat[39:32] !== 8'h00) begin bad++; $display("FAIL mixed_clear got=%h exp=00", regFlat[39:32]); end
  endtask

  task automatic test_w1c();
    hwEvent[16] = 1'b1;
    @(negedge LpcClock);
    hwEvent = '0;
    total++; if (regFlat[23:16] !== 8'h01) begin bad++; $display("FAIL w1c_set got=%h exp=01", regFlat[23:16]); end
    repeat (2) @(negedge LpcClock);
    hwEvent[17] = 1'b1;
    writeReg(8'd2, 8'h01);
    hwEvent = '0;
    total++; if (regFlat[23:16] !== 8'h02) begin bad++; $display("FAIL w1c_clear_and_set got=%h exp=02", regFlat[23:16]); end
    hwEvent[16] = 1'b1;
    writeReg(8'd2, 8'h01);
    hwEvent = '0;
    total++; if (regFlat[23:16] !== 8'h03) begin bad++; $display("FAIL w1c_set_wins got=%h exp=03", regFlat[23:16]); end
    writeReg(8'd2, 8'hFF);
    total++; if (regFlat[23:16] !== 8'h00) begin bad++; $display("FAIL w1c_clear_all got=%h exp=00", regFlat[23:16]); end
  endtask

  task automatic test_irq();
    writeReg(8'd3, 8'h01);
    hwEvent[16] = 1'b1;
    @(negedge LpcClock);
    hwEvent = '0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_latency_early got=%b exp=0", irq); end
    @(negedge LpcClock);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_assert got=%b exp=1", irq); end
    writeReg(8'd2, 8'h01);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_clear_lag got=%b exp=1", irq); end
    @(negedge LpcClock);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_deassert got=%b exp=0", irq); end
    writeReg(8'd3, 8'h00);
    hwEvent[16] = 1'b1;
    @(negedge LpcClock);
    hwEvent = '0;
    repeat (2) @(negedge LpcClock);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", irq); end
    writeReg(8'd2, 8'hFF);
  endtask

  task automatic test_read_port();
    writeReg(8'd1, 8'hAA);
    sbQ.push_back(8'hAA);
    bus.Addr = 8'd1; bus.DataWrSW = 8'h33; bus.Wr = 1'b1; bus.Rd = 1'b1;
    @(negedge LpcClock);
    bus.Wr = 1'b0; bus.Rd = 1'b0;
    total++; if (regFlat[15:8] !== 8'h33) begin bad++; $display("FAIL rdwr_new_value got=%h exp=33", regFlat[15:8]); end
    readReg(8'd1, 8'h33);
    @(negedge LpcClock);
    total++; if (bus.DataRd !== 8'h33) begin bad++; $display("FAIL datard_hold got=%h exp=33", bus.DataRd); end
    total++; if (bus.RdValid !== 1'b0) begin bad++; $display("FAIL rdvalid_one_cycle got=%b exp=0", bus.RdValid); end
    readReg(8'h40, 8'hFF);
    readReg(8'h20, 8'hFF);
    readReg(8'd0, 8'h5A);
    writeReg(8'h21, 8'h00);
    total++; if (wrPulse !== 32'h0) begin bad++; $display("FAIL oor_write_pulse got=%h exp=0", wrPulse); end
    total++; if (regFlat[15:8] !== 8'h33) begin bad++; $display("FAIL oor_write_alias got=%h exp=33", regFlat[15:8]); end
  endtask

  task automatic test_back_to_back();
    writeReg(8'd3, 8'h5C);
    writeReg(8'd1, 8'h96);
    readReg(8'd3, 8'h5C);
    readReg(8'd1, 8'h96);
    readReg(8'd0, 8'h5A);
    @(negedge LpcClock);
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) begin
      bus8.Addr = 3'(i); bus8.DataWrSW = 8'(8'h10 + i); bus8.Wr = 1'b1;
      @(negedge LpcClock);
      total++; if (wrPulse8 !== 8'(1 << i)) begin bad++; $display("FAIL sweep_wrpulse idx=%0d got=%h exp=%h", i, wrPulse8, 8'(1 << i)); end
    end
    bus8.Wr = 1'b0;
    @(negedge LpcClock);
    total++; if (wrPulse8 !== 8'h00) begin bad++; $display("FAIL sweep_wrpulse_idle got=%h exp=00", wrPulse8); end
    total++; if (regFlat8 !== 64'h1716151413121110) begin bad++; $display("FAIL sweep_regflat got=%h exp=1716151413121110", regFlat8); end
  endtask

  initial begin
    PciReset = 1'b0;
    bus.Addr = '0; bus.Wr = 1'b0; bus.Rd = 1'b0; bus.DataWrSW = '0;
    bus8.Addr = '0; bus8.Wr = 1'b0; bus8.Rd = 1'b0; bus8.DataWrSW = '0;
    hwVal = '0; hwEvent = '0; hwVal8 = '0; hwEvent8 = '0;
    fork
      monitorRd();
    join_none
    test_reset();
    test_mixed_masks();
    test_w1c();
    test_irq();
    test_read_port();
    test_back_to_back();
    test_sweep();
    total++;
    if (sbQ.size() != 0) begin
      bad++;
      $display("FAIL read_outstanding got=%0d exp=0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
